// File: rtl/divu_seq_x3y3_pkg.sv
// Shared configuration for the sequential unsigned divider: widths, output bit positions and FSM encodings.
// X_WIDTH/Y_WIDTH and the O_*_BITID positions may be overridden on the command line before this file is read.
`ifndef X_WIDTH
`define X_WIDTH 3
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 3
`endif
`ifndef O_Q_BITID
`define O_Q_BITID 0
`endif
`ifndef O_R_BITID
`define O_R_BITID (`O_Q_BITID + `X_WIDTH)
`endif
`ifndef O_READY_BITID
`define O_READY_BITID (`O_R_BITID + `Y_WIDTH)
`endif
`ifndef O_DZ_BITID
`define O_DZ_BITID (`O_READY_BITID + 1)
`endif

package divu_seq_x3y3_pkg;

    localparam int CFG_X_WIDTH = `X_WIDTH;
    localparam int CFG_Y_WIDTH = `Y_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

    // Iteration counter width; a 1-bit dividend still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divu_seq_x3y3_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor, restore on borrow.
// Purely combinational; the comparison is done at Y_WIDTH+1 bits so the shifted remainder never overflows.
module divu_step #(
    parameter int Y_WIDTH = 3
) (
    input  logic [Y_WIDTH-1:0] rem_i,
    input  logic [Y_WIDTH-1:0] dvs_i,
    input  logic               bit_i,
    output logic [Y_WIDTH-1:0] rem_o,
    output logic               qbit_o
);

    logic [Y_WIDTH:0] shifted;

    assign shifted = {rem_i, bit_i};
    assign qbit_o  = (shifted >= {1'b0, dvs_i});
    // When the trial succeeds the difference is below the divisor, so the low bits are exact.
    assign rem_o   = qbit_o ? (shifted[Y_WIDTH-1:0] - dvs_i) : shifted[Y_WIDTH-1:0];

endmodule

// File: rtl/divu_seq_x3y3.sv
// Sequential restoring unsigned divider: one quotient bit per clock, result qualified by rdy.
// Build option DIVZERO_FLAG_EN adds the dz port and a one-edge shortcut for a zero divisor.
module divu_seq_x3y3
    import divu_seq_x3y3_pkg::*;
#(
    parameter int X_WIDTH = CFG_X_WIDTH,
    parameter int Y_WIDTH = CFG_Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    output logic [X_WIDTH-1:0] q,
    output logic [Y_WIDTH-1:0] r,
`ifdef DIVZERO_FLAG_EN
    output logic               dz,
`endif
    output logic               rdy
);

    localparam int CW = cnt_width(X_WIDTH);

    state_t             state_q, state_d;
    logic [X_WIDTH-1:0] xa_q, xa_d;
    logic [Y_WIDTH-1:0] ya_q, ya_d;
    logic [Y_WIDTH-1:0] rem_q, rem_d;
    logic [X_WIDTH-1:0] qacc_q, qacc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [X_WIDTH-1:0] q_q, q_d;
    logic [Y_WIDTH-1:0] r_q, r_d;
    logic               rdy_q, rdy_d;
`ifdef DIVZERO_FLAG_EN
    logic               dz_q, dz_d;
`endif

    logic [Y_WIDTH-1:0] step_rem;
    logic               step_qbit;
    logic               latch;

    divu_step #(.Y_WIDTH(Y_WIDTH)) u_step (
        .rem_i  (rem_q),
        .dvs_i  (ya_q),
        .bit_i  (xa_q[cnt_q]),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        rem_d   = rem_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        rdy_d   = rdy_q;
`ifdef DIVZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        latch   = 1'b0;

        case (state_q)
            IDLE: latch = 1'b1;
            BUSY: begin
                rem_d  = step_rem;
                qacc_d = (qacc_q << 1) | X_WIDTH'(step_qbit);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    q_d     = qacc_d;
                    r_d     = step_rem;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: latch = (x != xa_q) || (y != ya_q);
            default: state_d = IDLE;
        endcase

        // Operands are sampled only here, so changes during BUSY are deferred to DONE.
        if (latch) begin
            xa_d    = x;
            ya_d    = y;
            rem_d   = '0;
            qacc_d  = '0;
            cnt_d   = CW'(X_WIDTH - 1);
            rdy_d   = 1'b0;
            state_d = BUSY;
`ifdef DIVZERO_FLAG_EN
            if (y == '0) begin
                q_d     = '1;
                r_d     = Y_WIDTH'(x);
                dz_d    = 1'b1;
                rdy_d   = 1'b1;
                state_d = DONE;
            end else begin
                dz_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xa_q    <= '0;
            ya_q    <= '0;
            rem_q   <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            rdy_q   <= 1'b0;
`ifdef DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            rem_q   <= rem_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            rdy_q   <= rdy_d;
`ifdef DIVZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign q   = q_q;
    assign r   = r_q;
    assign rdy = rdy_q;
`ifdef DIVZERO_FLAG_EN
    assign dz  = dz_q;
`endif

endmodule

// File: tb/tb_divu_seq_x3y3.sv
// Randomized and directed bench for divu_seq_x3y3 against an arithmetic reference model.
// Honours DIVZERO_FLAG_EN for the dz port and the zero-divisor latency.
module tb_divu_seq_x3y3;

    localparam int XW = 3;
    localparam int YW = 3;
    localparam int MAX_EDGES = 20;

    logic          clk;
    logic          rst;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] q;
    logic [YW-1:0] r;
    logic          rdy;
`ifdef DIVZERO_FLAG_EN
    logic          dz;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int px, py;

    divu_seq_x3y3 #(.X_WIDTH(XW), .Y_WIDTH(YW)) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .q   (q),
        .r   (r),
`ifdef DIVZERO_FLAG_EN
        .dz  (dz),
`endif
        .rdy (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input int xv, input int yv, output int qv, output int rv);
        if (yv == 0) begin
            qv = (1 << XW) - 1;
            rv = xv % (1 << YW);
        end else begin
            qv = xv / yv;
            rv = xv % yv;
        end
    endfunction

    function automatic int ref_latency(input int yv);
`ifdef DIVZERO_FLAG_EN
        if (yv == 0) return 1;
`endif
        return 1 + XW;
    endfunction

    task automatic step_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Edges until rdy is seen high, bounded; a timeout shows up as a latency mismatch.
    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            step_edge();
            n++;
        end while (!rdy && n < MAX_EDGES);
    endtask

    task automatic check_result(input string tag, input int xv, input int yv);
        int qv, rv;
        ref_div(xv, yv, qv, rv);
        chk({tag, "_q"}, q, qv);
        chk({tag, "_r"}, r, rv);
`ifdef DIVZERO_FLAG_EN
        chk({tag, "_dz"}, dz, (yv == 0) ? 1 : 0);
`endif
    endtask

    task automatic run_op(input string tag, input int xv, input int yv);
        int n;
        if (xv == px && yv == py) begin
            step_edge();
            chk({tag, "_hold_rdy"}, rdy, 1);
        end else begin
            x = XW'(xv);
            y = YW'(yv);
            wait_rdy(n);
            chk({tag, "_lat"}, n, ref_latency(yv));
        end
        check_result(tag, xv, yv);
        px = xv;
        py = yv;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        x = 3'd6;
        y = 3'd3;
        repeat (2) step_edge();
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_rdy", rdy, 0);
`ifdef DIVZERO_FLAG_EN
        chk("rst_dz", dz, 0);
`endif

        rst = 1'b0;
        wait_rdy(n);
        chk("first_lat", n, 1 + XW);
        check_result("first", 6, 3);
        px = 6;
        py = 3;

        run_op("x7y2", 7, 2);
        run_op("x5y0", 5, 0);

        // Operand change one edge into BUSY is deferred until DONE.
        x = 3'd7;
        y = 3'd3;
        step_edge();
        step_edge();
        x = 3'd4;
        y = 3'd1;
        n = 2;
        while (!rdy && n < MAX_EDGES) begin
            step_edge();
            n++;
        end
        chk("busy_chg_lat1", n, 1 + XW);
        check_result("busy_chg_first", 7, 3);
        step_edge();
        chk("busy_chg_relatch_rdy", rdy, 0);
        chk("busy_chg_hold_q", q, 2);
        chk("busy_chg_hold_r", r, 1);
        n = 1;
        while (!rdy && n < MAX_EDGES) begin
            step_edge();
            n++;
        end
        chk("busy_chg_lat2", n, 1 + XW);
        check_result("busy_chg_second", 4, 1);

        // Reset mid-operation abandons it; the current operands restart from IDLE.
        x = 3'd5;
        y = 3'd2;
        step_edge();
        step_edge();
        rst = 1'b1;
        step_edge();
        chk("midrst_q", q, 0);
        chk("midrst_r", r, 0);
        chk("midrst_rdy", rdy, 0);
        rst = 1'b0;
        wait_rdy(n);
        chk("midrst_lat", n, 1 + XW);
        check_result("midrst", 5, 2);
        px = 5;
        py = 2;

        for (int xi = 0; xi < (1 << XW); xi++) begin
            for (int yi = 0; yi < (1 << YW); yi++) begin
                int qv, rv;
                run_op("sweep", xi, yi);
                ref_div(xi, yi, qv, rv);
                step_edge();
                chk("sweep_hold_rdy", rdy, 1);
                chk("sweep_hold_q", q, qv);
            end
        end

        for (int i = 0; i < 40; i++) begin
            int xv, yv;
            if ($urandom_range(0, 3) == 0) begin
                xv = px;
                yv = py;
            end else begin
                xv = $urandom_range(0, (1 << XW) - 1);
                yv = $urandom_range(0, (1 << YW) - 1);
            end
            run_op("rand", xv, yv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divu_seq_x3y3.md
DIVU_SEQ_X3Y3 -- requirements
Module: divu_seq_x3y3

Interface
REQ-001 SHALL have parameter X_WIDTH, default 3 (`X_WIDTH from config.vh): dividend width.
REQ-002 SHALL have parameter Y_WIDTH, default 3 (`Y_WIDTH from config.vh): divisor width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 x  input  X_WIDTH  unsigned dividend.
REQ-006 y  input  Y_WIDTH  unsigned divisor.
REQ-007 q  output  X_WIDTH  registered quotient.
REQ-008 r  output  Y_WIDTH  registered remainder.
REQ-009 rdy  output  1  high when q/r hold the result of the currently latched operands.
REQ-010 dz  output  1  divide-by-zero flag; present only per REQ-027.

Function
REQ-011 SHALL compute the restoring unsigned division x = q*y + r, with r < y when y != 0.
REQ-012 SHALL use FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: at the next edge, latch x/y into operand registers, clear the partial remainder, load count = X_WIDTH-1, and go to BUSY.
REQ-014 BUSY: produce one quotient bit per edge, MSB first, by shift, trial-subtract and restore.
REQ-015 BUSY with count = 0: write q/r, set rdy = 1, and go to DONE.
REQ-016 Latency SHALL be 1 + X_WIDTH edges from IDLE to rdy = 1 (4 edges at default width).
REQ-017 DONE: hold q/r/rdy unchanged while x/y equal the latched operands.
REQ-018 DONE with x or y different from the latched operands: at that edge, relatch, clear rdy, and go to BUSY; the new result follows X_WIDTH edges later.
REQ-019 Operand changes during BUSY SHALL be ignored; the in-flight division completes, then REQ-018 applies in DONE.
REQ-020 q/r SHALL keep their previous values during BUSY; only rdy qualifies them.
REQ-021 y = 0 without DIVZERO_FLAG_EN: run the full X_WIDTH iterations; result q = all ones, r = x[Y_WIDTH-1:0].
REQ-022 Remainder arithmetic SHALL use Y_WIDTH+1 bits so the trial subtraction never overflows.

Reset
REQ-023 rst at an edge SHALL force state = IDLE, q = 0, r = 0, rdy = 0, dz = 0, and clear operand registers and count.
REQ-024 rst during BUSY or DONE SHALL abandon the operation with no partial result visible.
REQ-025 After rst deasserts, the block SHALL restart from IDLE with the current x/y per REQ-013.
REQ-026 rst SHALL take priority over every FSM transition.

Configuration
REQ-027 Macro DIVZERO_FLAG_EN defined:
- dz port present.
- IDLE/DONE latching y = 0 goes directly to DONE at the next edge.
- Outputs on entering DONE: q = all ones, r = x[Y_WIDTH-1:0], dz = 1, rdy = 1.
- dz clears whenever a nonzero divisor is latched.
REQ-028 Macro DIVZERO_FLAG_EN undefined: dz port absent; y = 0 handled only by REQ-021.

Structure
REQ-029 Widths and io bit positions SHALL live in shared config.vh:
- `X_WIDTH, `Y_WIDTH.
- `O_Q_BITID, `O_R_BITID, `O_DZ_BITID, `O_READY_BITID.
REQ-030 FSM state encodings SHALL be localparams in global.vh.
REQ-031 One combinational sub-module divu_step SHALL perform a single shift/trial-subtract/restore iteration: inputs partial remainder, divisor, next dividend bit; outputs next remainder and quotient bit.

Verification
REQ-032 Reset, then x=6, y=3 -> rdy rises 4 edges after rst release; q=2, r=0.
REQ-033 In DONE, change to x=7, y=2 -> rdy=0 at the next edge; q=3, r=1, rdy=1 three edges later.
REQ-034 x=5, y=0 -> with DIVZERO_FLAG_EN: q=7, r=5, dz=1 after 1 edge; without: q=7, r=5 after 4 edges.
REQ-035 Start x=7, y=3; switch to x=4, y=1 one edge into BUSY -> first q=2, r=1 with rdy=1; then rdy=0 for 3 edges, then q=4, r=0.
REQ-036 Assert rst mid-BUSY -> q=0, r=0, rdy=0 at that edge; after release, the correct result appears 4 edges later.
REQ-037 All 64 (x, y) pairs applied sequentially -> every rdy=1 result matches a reference model; no rdy glitch while operands are held.
